queue_param: RTL and testbench
==============================

Name: queue_param

Overview:
Parametrised successor of the 8x8 byte queue: a synchronous circular FIFO with configurable data width and depth (including non-power-of-two depths). It adds well-defined simultaneous enqueue/dequeue, full/empty/almost flags, a read-valid strobe, a synchronous flush, and sticky overflow/underflow error flags. It sits between the serial-to-parallel deserialiser front end and the byte consumer, in the same clock_10 domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, need not be a power of two)
AF_LEVEL, DEPTH-2, almost_full_out asserts when len_out >= AF_LEVEL
AE_LEVEL, 2, almost_empty_out asserts when len_out <= AE_LEVEL
LW, $clog2(DEPTH+1), width of len_out (derived, not overridden)

Ports:
clock_10  input  1  system clock (10 kHz); all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  word to enqueue
enq_in  input  1  enqueue request, sampled each rising edge
deq_in  input  1  dequeue request, sampled each rising edge
clear_in  input  1  synchronous flush
data_out  output  WIDTH  last dequeued word (registered)
valid_out  output  1  one-cycle pulse: data_out updated this cycle
len_out  output  LW  current occupancy, 0..DEPTH
full_out  output  1  len_out == DEPTH
empty_out  output  1  len_out == 0
almost_full_out  output  1  len_out >= AF_LEVEL
almost_empty_out  output  1  len_out <= AE_LEVEL
status_out  output  1  one-cycle error pulse (rejected enq or deq)
overflow_out  output  1  sticky: an enqueue was rejected
underflow_out  output  1  sticky: a dequeue was rejected

Behaviour:
- Reset (async assert, removal synchronous to clock_10): head=tail=0, len_out=0, data_out=0, valid_out=0, status_out=0, overflow_out=0, underflow_out=0. Derived flags: empty_out=1, full_out=0, almost_empty_out=1, almost_full_out=0. Storage contents are not reset.
- Reset mid-operation discards all contents and any request pending in that cycle.
- Flags full/empty/almost are combinational decodes of the len_out register, so they are valid in the same cycle as len_out.
- Priority per edge: reset > clear_in > enq/deq.
- clear_in=1: head=tail=len=0, sticky flags cleared, valid_out=0, status_out=0. data_out holds. Enq/deq in the same cycle are ignored.
- Enqueue is accepted when enq_in=1 and (len<DEPTH, or deq_in=1 with len==DEPTH). On accept: mem[tail]<=data_in, and tail advances.
- Dequeue is accepted when deq_in=1 and len>0. On accept: data_out<=mem[head], head advances, valid_out=1 on the next cycle. Read latency is one clock. There is no empty bypass: an enq and deq issued on an empty queue accept the enq and reject the deq.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. Plain increment-and-wrap; no modulo by a power of two assumed.
- len update: +1 on enq only; -1 on deq only; unchanged when both are accepted. Exactly one assignment per cycle.
- Both requests accepted when full: the head word is read out and the new word written into the freed slot; len stays at DEPTH.
- Rejected enq (full, no deq): storage and tail unchanged; status_out=1 for one cycle; overflow_out<=1.
- Rejected deq (empty): data_out holds; valid_out=0; status_out=1; underflow_out<=1. If both requests are rejected in the same cycle, status_out is a single pulse.
- status_out and valid_out default to 0 every cycle they are not set.
- Simulation-only $display trace lines are permitted; they have no functional effect.

Test Plan:
1. Reset, then enq 0x11,0x22,0x33 on consecutive cycles, then deq x3 -> data_out 0x11,0x22,0x33, each one cycle after its deq with valid_out pulses; len_out 3->0; empty_out=1.
2. DEPTH=8: enq 8 words -> full_out=1 and almost_full_out set from len 6. A 9th enq (0xAA) -> status_out pulse, overflow_out=1, len stays 8. Dequeue all -> 0xAA is absent from the output.
3. When full, assert enq(0x5C)+deq together -> data_out = oldest word, len stays 8. Drain -> 0x5C comes out last.
4. When empty, assert deq -> status_out pulse, underflow_out=1, data_out unchanged. Assert enq(0x7E)+deq together -> len=1, underflow pulse again.
5. DEPTH=5, WIDTH=12: push/pop 13 words interleaved (enq 3, deq 2, repeat) -> FIFO order preserved across pointer wrap (tail passes 4->0 at least twice).
6. With len=4, assert clear_in together with enq -> len=0, empty_out=1, sticky flags 0. Assert reset mid-burst -> all outputs at their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/queue_param.sv
// queue_param: parametrised synchronous circular FIFO.
// Sits between the deserialiser front end and the byte consumer in the
// clock_10 domain. Supports any DEPTH >= 2, not only powers of two.
//
// Request semantics (no ready/valid back-pressure; requests are one-shot):
//   enq_in and deq_in are sampled on every rising edge of clock_10. A
//   request that cannot be honoured is dropped, status_out pulses for one
//   cycle, and the matching sticky error flag is set. An accepted dequeue
//   loads data_out on that edge, and valid_out is high for the following
//   cycle only. clear_in takes priority over both requests.
module queue_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic             clock_10,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enq_in,
  input  logic             deq_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [LW-1:0]    len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             almost_full_out,
  output logic             almost_empty_out,
  output logic             status_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  // Pointer width: enough to index DEPTH entries.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEN    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_LEN    = LW'(AE_LEVEL);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             status_q, status_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             enq_ok;
  logic             deq_ok;
  logic             mem_we;

  // Increment-and-wrap that does not rely on a power-of-two depth.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Acceptance: a full queue still takes a write when a read frees a slot
  // on the same edge; an empty queue never bypasses data to the reader.
  always_comb begin
    enq_ok = enq_in && ((len_q != DEPTH_LEN) || deq_in);
    deq_ok = deq_in && (len_q != '0);
  end

  // Next-state computation; clear_in overrides any request in its cycle.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    len_d       = len_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    status_d    = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;

    if (clear_in) begin
      head_d      = '0;
      tail_d      = '0;
      len_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (enq_ok) begin
        mem_we = 1'b1;
        tail_d = ptr_next(tail_q);
      end
      if (deq_ok) begin
        data_out_d = mem_q[head_q];
        head_d     = ptr_next(head_q);
        valid_d    = 1'b1;
      end
      // Exactly one length update; a simultaneous enq/deq leaves it alone.
      case ({enq_ok, deq_ok})
        2'b10:   len_d = len_q + 1'b1;
        2'b01:   len_d = len_q - 1'b1;
        default: len_d = len_q;
      endcase
      // A single status pulse covers either or both rejected requests.
      if ((enq_in && !enq_ok) || (deq_in && !deq_ok)) begin
        status_d = 1'b1;
      end
      if (enq_in && !enq_ok) begin
        overflow_d = 1'b1;
      end
      if (deq_in && !deq_ok) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control and output registers, asynchronously reset.
  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      len_q       <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      status_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      len_q       <= len_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      status_q    <= status_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port; when full with both requests, tail equals head and
  // the old word is read out on the same edge the new one is written.
  always_ff @(posedge clock_10) begin
    if (mem_we && !reset) begin
      mem_q[tail_q] <= data_in;
    end
  end

  // Registered outputs and flag decodes of the length register.
  assign data_out         = data_out_q;
  assign valid_out        = valid_q;
  assign len_out          = len_q;
  assign status_out       = status_q;
  assign overflow_out     = overflow_q;
  assign underflow_out    = underflow_q;
  assign full_out         = (len_q == DEPTH_LEN);
  assign empty_out        = (len_q == '0);
  assign almost_full_out  = (len_q >= AF_LEN);
  assign almost_empty_out = (len_q <= AE_LEN);

endmodule

// File: tb/tb_queue_param.sv
// Directed testbench for queue_param: an 8x8 instance and a 5x12 instance.
module tb_queue_param;

  logic clk;
  logic reset;

  // Instance A: WIDTH=8, DEPTH=8
  logic [7:0]  a_data_in;
  logic        a_enq, a_deq, a_clr;
  logic [7:0]  a_data_out;
  logic        a_valid;
  logic [3:0]  a_len;
  logic        a_full, a_empty, a_af, a_ae, a_status, a_ovf, a_unf;

  // Instance B: WIDTH=12, DEPTH=5
  logic [11:0] b_data_in;
  logic        b_enq, b_deq, b_clr;
  logic [11:0] b_data_out;
  logic        b_valid;
  logic [2:0]  b_len;
  logic        b_full, b_empty, b_af, b_ae, b_status, b_ovf, b_unf;

  int checks = 0;
  int fails  = 0;

  logic [11:0] exp_q[$];

  queue_param #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clock_10(clk), .reset(reset), .data_in(a_data_in),
    .enq_in(a_enq), .deq_in(a_deq), .clear_in(a_clr),
    .data_out(a_data_out), .valid_out(a_valid), .len_out(a_len),
    .full_out(a_full), .empty_out(a_empty),
    .almost_full_out(a_af), .almost_empty_out(a_ae),
    .status_out(a_status), .overflow_out(a_ovf), .underflow_out(a_unf)
  );

  queue_param #(.WIDTH(12), .DEPTH(5)) dut_b (
    .clock_10(clk), .reset(reset), .data_in(b_data_in),
    .enq_in(b_enq), .deq_in(b_deq), .clear_in(b_clr),
    .data_out(b_data_out), .valid_out(b_valid), .len_out(b_len),
    .full_out(b_full), .empty_out(b_empty),
    .almost_full_out(b_af), .almost_empty_out(b_ae),
    .status_out(b_status), .overflow_out(b_ovf), .underflow_out(b_unf)
  );

  // Clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on A; called #1 after a rising edge, returns #1 after the next.
  task automatic a_step(input logic e, input logic d, input logic c, input logic [7:0] w);
    a_enq = e; a_deq = d; a_clr = c; a_data_in = w;
    @(posedge clk); #1;
    a_enq = 1'b0; a_deq = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_step(input logic e, input logic d, input logic [11:0] w);
    b_enq = e; b_deq = d; b_data_in = w;
    @(posedge clk); #1;
    b_enq = 1'b0; b_deq = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_len"},    a_len,      0);
    check({tag, "_empty"},  a_empty,    1);
    check({tag, "_full"},   a_full,     0);
    check({tag, "_ae"},     a_ae,       1);
    check({tag, "_af"},     a_af,       0);
    check({tag, "_dout"},   a_data_out, 0);
    check({tag, "_valid"},  a_valid,    0);
    check({tag, "_status"}, a_status,   0);
    check({tag, "_ovf"},    a_ovf,      0);
    check({tag, "_unf"},    a_unf,      0);
  endtask

  initial begin
    logic [7:0]  t1_vals [3];
    logic [11:0] v;
    logic [11:0] exp_w;
    int          b_len_exp;
    int          n;

    t1_vals[0] = 8'h11; t1_vals[1] = 8'h22; t1_vals[2] = 8'h33;
    a_enq = 0; a_deq = 0; a_clr = 0; a_data_in = '0;
    b_enq = 0; b_deq = 0; b_clr = 0; b_data_in = '0;

    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_a("rst");
    check("rst_b_empty", b_empty, 1);

    // 1: three words in, three out in order
    for (int i = 0; i < 3; i++) begin
      a_step(1, 0, 0, t1_vals[i]);
      check("t1_len_up", a_len, i + 1);
    end
    check("t1_empty_lo", a_empty, 0);
    for (int i = 0; i < 3; i++) begin
      a_step(0, 1, 0, 8'h00);
      check("t1_dout",  a_data_out, t1_vals[i]);
      check("t1_valid", a_valid, 1);
      check("t1_len_dn", a_len, 2 - i);
    end
    check("t1_empty", a_empty, 1);
    a_step(0, 0, 0, 8'h00);
    check("t1_valid_drop", a_valid, 0);

    // 2: fill to DEPTH, almost_full from len 6, overflow on the 9th
    for (int i = 0; i < 8; i++) begin
      a_step(1, 0, 0, 8'(i + 1));
      check("t2_len", a_len, i + 1);
      check("t2_af", a_af, (i + 1) >= 6);
      check("t2_ae", a_ae, (i + 1) <= 2);
    end
    check("t2_full", a_full, 1);
    a_step(1, 0, 0, 8'hAA);
    check("t2_ovf_status", a_status, 1);
    check("t2_ovf", a_ovf, 1);
    check("t2_ovf_len", a_len, 8);
    a_step(0, 0, 0, 8'h00);
    check("t2_status_pulse", a_status, 0);
    check("t2_ovf_sticky", a_ovf, 1);

    // 3: enq+deq while full, then drain (0xAA never appears, 0x5C last)
    a_step(1, 1, 0, 8'h5C);
    check("t3_dout", a_data_out, 8'h01);
    check("t3_valid", a_valid, 1);
    check("t3_len", a_len, 8);
    check("t3_status", a_status, 0);
    for (int i = 0; i < 8; i++) begin
      a_step(0, 1, 0, 8'h00);
      check("t3_drain", a_data_out, (i < 7) ? 8'(i + 2) : 8'h5C);
      check("t3_drain_valid", a_valid, 1);
    end
    check("t3_empty", a_empty, 1);

    // 4: underflow, then enq+deq on empty
    a_step(0, 1, 0, 8'h00);
    check("t4_status", a_status, 1);
    check("t4_unf", a_unf, 1);
    check("t4_valid", a_valid, 0);
    check("t4_dout_hold", a_data_out, 8'h5C);
    a_step(1, 1, 0, 8'h7E);
    check("t4_both_len", a_len, 1);
    check("t4_both_status", a_status, 1);
    check("t4_both_valid", a_valid, 0);

    // 6a: clear with enq at len 4
    a_step(1, 0, 0, 8'h41);
    a_step(1, 0, 0, 8'h42);
    a_step(1, 0, 0, 8'h43);
    check("t6_len4", a_len, 4);
    a_step(1, 0, 1, 8'h99);
    check("t6_clr_len", a_len, 0);
    check("t6_clr_empty", a_empty, 1);
    check("t6_clr_ovf", a_ovf, 0);
    check("t6_clr_unf", a_unf, 0);
    check("t6_clr_status", a_status, 0);
    check("t6_clr_dout", a_data_out, 8'h5C);
    a_step(1, 0, 0, 8'hA1);
    a_step(1, 0, 0, 8'hA2);
    a_step(0, 1, 0, 8'h00);
    check("t6_after_clr", a_data_out, 8'hA1);
    check("t6_after_clr_valid", a_valid, 1);

    // 6b: asynchronous reset mid-burst, checked before any clock edge
    a_enq = 1'b1; a_data_in = 8'hA3;
    #20 reset = 1'b1;
    #1;
    check_reset_a("arst");
    a_enq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_a("arst_hold");

    // 5: DEPTH=5, WIDTH=12 interleaved traffic across pointer wrap
    b_len_exp = 0;
    n = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) begin
        // round pattern E E D E D; the fifth round is a single E
        if (r == 4 && k > 0) break;
        if (k == 2 || k == 4) begin
          b_step(0, 1, 12'h000);
          exp_w = exp_q.pop_front();
          b_len_exp--;
          check("t5_dout", b_data_out, exp_w);
          check("t5_valid", b_valid, 1);
        end else begin
          v = 12'(32'h0A5 + n * 32'h1F3);
          n++;
          exp_q.push_back(v);
          b_step(1, 0, v);
          b_len_exp++;
        end
        check("t5_len", b_len, b_len_exp);
      end
    end
    check("t5_pushes", n, 13);
    check("t5_full", b_full, 1);
    check("t5_af", b_af, 1);
    check("t5_no_ovf", b_ovf, 0);
    for (int i = 0; i < 5; i++) begin
      b_step(0, 1, 12'h000);
      exp_w = exp_q.pop_front();
      check("t5_drain", b_data_out, exp_w);
      check("t5_drain_valid", b_valid, 1);
    end
    check("t5_empty", b_empty, 1);
    check("t5_no_unf", b_unf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
